// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0020;

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - power-of-two FIFO with synchronous flush, no bypass
module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty queue is ignored; a push at full is accepted only when a pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush wins over a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents past the pointers are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - prefetching instruction fetch unit with redirect support
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  start_up,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_rvalid,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic [31:0]           fetch_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e                     state, state_next;
  logic [ADDR_WIDTH-1:0]            fetch_pc;
  logic                             epoch;
  logic                             inflight_valid;
  logic                             inflight_epoch;
  logic [ADDR_WIDTH-1:0]            inflight_addr;
  logic [CW-1:0]                    occ;
  logic [CW:0]                      pending;
  logic                             has_space;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             resp_ok;
  logic                             pop_fire;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

  // Queued entries plus the outstanding request must never exceed the queue size.
  assign pending   = {1'b0, occ} + (CW+1)'(inflight_valid);
  assign has_space = !fifo_full && (pending < (CW+1)'(DEPTH));

  // Responses from a request issued before the last redirect carry a stale epoch.
  assign resp_ok  = imem_rvalid && inflight_valid && (inflight_epoch == epoch);
  assign pop_fire = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = !fifo_empty && !start_up;
  assign instr       = instr_valid ? head[DATA_WIDTH-1:0] : '0;
  assign instr_pc    = instr_valid ? head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign imem_addr   = start_up ? RESET_PC : fetch_pc;

  // Next-state and request decode; redirect and reset suppress the request this cycle.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH: begin
        if (has_space) imem_req = 1'b1;
        else           state_next = STALL;
      end
      STALL:   if (has_space || pop_fire) state_next = FETCH;
      default: state_next = IDLE;
    endcase
    if (start_up || redirect_valid) begin
      imem_req   = 1'b0;
      state_next = FETCH;
    end
  end

  // Fetch PC, epoch, in-flight tracking and consumer count.
  always_ff @(posedge clk) begin
    if (start_up) begin
      state          <= IDLE;
      fetch_pc       <= RESET_PC;
      epoch          <= 1'b0;
      inflight_valid <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_addr  <= RESET_PC;
      fetch_count    <= '0;
    end else begin
      state          <= state_next;
      inflight_valid <= imem_req;
      inflight_epoch <= epoch;
      inflight_addr  <= fetch_pc;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        epoch    <= ~epoch;
      end else if (imem_req) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
      end
      if (pop_fire) fetch_count <= fetch_count + 32'd1;
    end
  end

  instr_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (start_up),
    .flush     (redirect_valid),
    .push      (resp_ok),
    .push_data ({inflight_addr, imem_rdata}),
    .pop       (pop_fire),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occ)
  );

endmodule
